// File: rtl/vend_pkg.sv
// Shared constants and types for the vending-machine credit path.
// Coin codes, coin values, credit width and the controller state enum.
package vend_pkg;

    localparam int CREDIT_W   = 5;
    localparam int CREDIT_MAX = 31;

    localparam logic [1:0] COIN_NICKEL  = 2'd0;
    localparam logic [1:0] COIN_DIME    = 2'd1;
    localparam logic [1:0] COIN_QUARTER = 2'd2;
    localparam logic [1:0] COIN_INVALID = 2'd3;

    localparam logic [CREDIT_W-1:0] VAL_NICKEL  = 5'd1;
    localparam logic [CREDIT_W-1:0] VAL_DIME    = 5'd2;
    localparam logic [CREDIT_W-1:0] VAL_QUARTER = 5'd5;

    typedef enum logic [1:0] {
        COLLECT,
        VEND,
        CHANGE
    } vend_state_t;

endpackage

// File: rtl/vend_credit_fsm_coin_decode.sv
// Coin code to credit-unit value, with a flag for unrecognised codes.
module coin_decode
    import vend_pkg::*;
(
    input  logic [1:0]          coin_type,
    output logic [CREDIT_W-1:0] value,
    output logic                invalid
);

    always_comb begin
        value   = '0;
        invalid = 1'b0;
        unique case (coin_type)
            COIN_NICKEL:  value = VAL_NICKEL;
            COIN_DIME:    value = VAL_DIME;
            COIN_QUARTER: value = VAL_QUARTER;
            default:      invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/vend_credit_fsm.sv
// Coin collection, vend and nickel-change control; mirrors credit into ex25.
// Optional cancel/refund path enabled by defining VEND_CANCEL_EN.
module vend_credit_fsm
    import vend_pkg::*;
#(
    parameter int PRICE = 15
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    output logic                coin_ready,
    output logic                coin_reject,
    input  logic                cancel,
    output logic                vend,
    output logic                change_valid,
    input  logic                change_ack,
    output logic                reg_load,
    output logic                reg_clear,
    output logic [CREDIT_W-1:0] reg_d
);

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    vend_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] coin_val;
    logic                coin_bad;
    logic [CREDIT_W:0]   sum;
    logic                reject_d, load_d, clr_d;

    coin_decode u_dec (
        .coin_type (coin_type),
        .value     (coin_val),
        .invalid   (coin_bad)
    );

    assign sum = {1'b0, credit_q} + {1'b0, coin_val};

`ifndef VEND_CANCEL_EN
    logic unused_cancel;
    assign unused_cancel = cancel;
`endif

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        load_d   = 1'b0;
        clr_d    = 1'b0;
        unique case (1'b1)
            state_q == COLLECT: begin
                if (coin_valid && coin_ready) begin
                    if (!coin_bad && sum <= (CREDIT_W+1)'(CREDIT_MAX)) begin
                        credit_d = sum[CREDIT_W-1:0];
                        load_d   = 1'b1;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
                // a coin completing the price beats a same-cycle cancel
                if (credit_d >= PRICE_C)
                    state_d = VEND;
`ifdef VEND_CANCEL_EN
                else if (cancel && credit_d != '0)
                    state_d = CHANGE;
`endif
            end
            state_q == VEND: begin
                credit_d = credit_q - PRICE_C;
                if (credit_d == '0) begin
                    clr_d   = 1'b1;
                    state_d = COLLECT;
                end else begin
                    load_d  = 1'b1;
                    state_d = CHANGE;
                end
            end
            state_q == CHANGE: begin
                if (change_ack && change_valid) begin
                    credit_d = credit_q - 5'd1;
                    if (credit_d == '0) begin
                        clr_d   = 1'b1;
                        state_d = COLLECT;
                    end else begin
                        load_d  = 1'b1;
                    end
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q      <= COLLECT;
            credit_q     <= '0;
            coin_ready   <= 1'b0;
            coin_reject  <= 1'b0;
            vend         <= 1'b0;
            change_valid <= 1'b0;
            reg_load     <= 1'b0;
            reg_clear    <= 1'b0;
        end else begin
            state_q      <= state_d;
            credit_q     <= credit_d;
            coin_ready   <= (state_d == COLLECT);
            coin_reject  <= reject_d;
            vend         <= (state_d == VEND);
            change_valid <= (state_d == CHANGE);
            reg_load     <= load_d;
            reg_clear    <= clr_d;
        end
    end

    assign reg_d = credit_q;

endmodule
